// File: rtl/montgomery_exp_if.sv
// Operand/result bus between the exponentiation controller
// and the Montgomery multiplier it drives.
interface montgomery_exp_if #(
  parameter int WIDTH = 512
);
  logic             mont_start;
  logic [WIDTH-1:0] mont_a;
  logic [WIDTH-1:0] mont_b;
  logic [WIDTH-1:0] mont_m;
  logic [WIDTH-1:0] mont_result;
  logic             mont_done;

  modport master (
    output mont_start,
    output mont_a,
    output mont_b,
    output mont_m,
    input  mont_result,
    input  mont_done
  );

  modport slave (
    input  mont_start,
    input  mont_a,
    input  mont_b,
    input  mont_m,
    output mont_result,
    output mont_done
  );
endinterface

// File: rtl/montgomery_exp.sv
// Left-to-right square-and-multiply X^E mod M built on an external
// Montgomery multiplier, with domain conversion in and out.
module montgomery_exp #(
  parameter int WIDTH = 512,
  parameter int LEN_W = 10
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_e,
  input  logic [LEN_W-1:0] in_e_len,
  input  logic [WIDTH-1:0] in_m,
  input  logic [WIDTH-1:0] in_r,
  input  logic [WIDTH-1:0] in_r2,
  output logic [WIDTH-1:0] result,
  output logic             done,
  montgomery_exp_if.master mont
);

  typedef enum logic [2:0] {
    IDLE, CONV_IN, SQR, MUL, CONV_OUT, WAIT, FIN
  } state_t;

  localparam logic [WIDTH-1:0] W_ONE  = WIDTH'(1);
  localparam logic [LEN_W-1:0] L_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] L_ZERO = '0;

  state_t           st;
  state_t           op;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] e_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r2_q;
  logic [WIDTH-1:0] xt_q;
  logic [WIDTH-1:0] acc_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] i_q;
  logic             e_bit;
  logic             last;

  // indices past WIDTH shift the mask out, so those bits read as 0
  assign e_bit = |(e_q & (W_ONE << i_q));
  assign last  = (i_q == L_ZERO);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      st              <= IDLE;
      op              <= IDLE;
      x_q             <= '0;
      e_q             <= '0;
      r_q             <= '0;
      r2_q            <= '0;
      xt_q            <= '0;
      acc_q           <= '0;
      len_q           <= '0;
      i_q             <= '0;
      result          <= '0;
      done            <= 1'b0;
      mont.mont_start <= 1'b0;
      mont.mont_a     <= '0;
      mont.mont_b     <= '0;
      mont.mont_m     <= '0;
    end else begin
      done            <= 1'b0;
      mont.mont_start <= 1'b0;
      unique case (st)
        IDLE: begin
          if (start) begin
            x_q         <= in_x;
            e_q         <= in_e;
            len_q       <= in_e_len;
            r_q         <= in_r;
            r2_q        <= in_r2;
            mont.mont_m <= in_m;
            st          <= CONV_IN;
          end
        end
        CONV_IN: begin
          mont.mont_a     <= x_q;
          mont.mont_b     <= r2_q;
          mont.mont_start <= 1'b1;
          acc_q           <= r_q;
          i_q             <= len_q - L_ONE;
          op              <= CONV_IN;
          st              <= WAIT;
        end
        SQR: begin
          mont.mont_a     <= acc_q;
          mont.mont_b     <= acc_q;
          mont.mont_start <= 1'b1;
          op              <= SQR;
          st              <= WAIT;
        end
        MUL: begin
          mont.mont_a     <= acc_q;
          mont.mont_b     <= xt_q;
          mont.mont_start <= 1'b1;
          op              <= MUL;
          st              <= WAIT;
        end
        CONV_OUT: begin
          mont.mont_a     <= acc_q;
          mont.mont_b     <= W_ONE;
          mont.mont_start <= 1'b1;
          op              <= CONV_OUT;
          st              <= WAIT;
        end
        WAIT: begin
          if (mont.mont_done) begin
            unique case (op)
              CONV_IN: begin
                xt_q <= mont.mont_result;
                st   <= (len_q == L_ZERO) ? CONV_OUT : SQR;
              end
              SQR: begin
                acc_q <= mont.mont_result;
                if (e_bit) begin
                  st <= MUL;
                end else if (last) begin
                  st <= CONV_OUT;
                end else begin
                  i_q <= i_q - L_ONE;
                  st  <= SQR;
                end
              end
              MUL: begin
                acc_q <= mont.mont_result;
                if (last) begin
                  st <= CONV_OUT;
                end else begin
                  i_q <= i_q - L_ONE;
                  st  <= SQR;
                end
              end
              default: begin
                acc_q <= mont.mont_result;
                st    <= FIN;
              end
            endcase
          end
        end
        FIN: begin
          result <= acc_q;
          done   <= 1'b1;
          st     <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_exp.sv
// Scoreboard bench for montgomery_exp with a 5-cycle REDC model
// standing in for the multiplier; M=13, R=256.
module tb_montgomery_exp;
  localparam int WIDTH = 8;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] in_x = '0;
  logic [WIDTH-1:0] in_e = '0;
  logic [LEN_W-1:0] in_e_len = '0;
  logic [WIDTH-1:0] in_m = 8'd13;
  logic [WIDTH-1:0] in_r = 8'd9;
  logic [WIDTH-1:0] in_r2 = 8'd3;
  logic [WIDTH-1:0] result;
  logic             done;

  montgomery_exp_if #(.WIDTH(WIDTH)) mif ();

  montgomery_exp #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk(clk),
    .resetn(resetn),
    .start(start),
    .in_x(in_x),
    .in_e(in_e),
    .in_e_len(in_e_len),
    .in_m(in_m),
    .in_r(in_r),
    .in_r2(in_r2),
    .result(result),
    .done(done),
    .mont(mif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // multiplier model: a*b*2^-8 mod m, done 5 cycles after start
  logic       md = 1'b0;
  logic       spur = 1'b0;
  logic [7:0] mres = '0;
  logic [7:0] spur_res = '0;
  int         busy = 0;
  int         lat = 0;
  int         unstable = 0;
  int         la, lb, lm;

  assign mif.mont_done   = md | spur;
  assign mif.mont_result = spur ? spur_res : mres;

  function automatic int redc(int a, int b, int m);
    int t;
    t = a * b;
    for (int k = 0; k < 8; k++) begin
      if (t % 2 != 0) t = t + m;
      t = t / 2;
    end
    if (t >= m) t = t - m;
    return t;
  endfunction

  always @(negedge clk) begin
    md = 1'b0;
    if (!resetn) begin
      busy = 0;
    end else begin
      if (busy != 0) begin
        if (int'(mif.mont_a) != la || int'(mif.mont_b) != lb ||
            int'(mif.mont_m) != lm)
          unstable++;
        lat--;
        if (lat == 0) begin
          md   = 1'b1;
          mres = 8'(redc(la, lb, lm));
          busy = 0;
        end
      end
      if (mif.mont_start) begin
        la   = int'(mif.mont_a);
        lb   = int'(mif.mont_b);
        lm   = int'(mif.mont_m);
        busy = 1;
        lat  = 5;
      end
    end
  end

  typedef struct {
    int res;
    int ops;
  } exp_t;

  exp_t q[$];
  int   ops = 0;
  int   n_done = 0;
  int   unstable_seen = 0;
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!resetn) begin
      ops       = 0;
      prev_done = 1'b0;
    end else begin
      if (mif.mont_start) ops++;
      if (done) begin
        n_done++;
        chk("done_width", int'(prev_done), 0);
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("result", int'(result), e.res);
          chk("op_count", ops, e.ops);
          chk("operand_stable", unstable, unstable_seen);
          unstable_seen = unstable;
        end
        ops = 0;
      end
      prev_done = done;
    end
  end

  task automatic pulse_start(int x, int e, int len);
    @(negedge clk);
    in_x     = 8'(x);
    in_e     = 8'(e);
    in_e_len = 4'(len);
    in_m     = 8'd13;
    in_r     = 8'd9;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    in_x     = 8'hA5;
    in_e     = 8'hFF;
    in_e_len = 4'hF;
    in_m     = 8'hFF;
    in_r     = 8'h00;
  endtask

  task automatic run(int x, int e, int len, int res, int nops, bit repulse);
    exp_t t;
    t.res = res;
    t.ops = nops;
    q.push_back(t);
    pulse_start(x, e, len);
    for (int c = 0; c < 400 && q.size() != 0; c++) begin
      if (repulse && c == 20) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    chk("timeout", q.size(), 0);
    q.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic check_outputs_zero();
    chk("rst_result", int'(result), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_mont_start", int'(mif.mont_start), 0);
    chk("rst_mont_a", int'(mif.mont_a), 0);
    chk("rst_mont_b", int'(mif.mont_b), 0);
    chk("rst_mont_m", int'(mif.mont_m), 0);
  endtask

  initial begin
    int d0;
    int starts;
    int seen;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero();
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    run(3, 5, 3, 9, 7, 1'b0);

    // spurious multiplier done while idle
    @(negedge clk);
    spur_res = 8'h55;
    spur     = 1'b1;
    @(negedge clk);
    spur     = 1'b0;
    d0       = n_done;
    starts   = 0;
    for (int c = 0; c < 10; c++) begin
      if (mif.mont_start) starts++;
      @(negedge clk);
    end
    chk("spur_result", int'(result), 9);
    chk("spur_done", n_done - d0, 0);
    chk("spur_start", starts, 0);

    run(3, 5, 8, 9, 12, 1'b0);
    run(7, 0, 0, 1, 2, 1'b0);
    run(0, 6, 3, 0, 7, 1'b0);

    d0 = n_done;
    run(2, 12, 4, 1, 8, 1'b1);
    repeat (20) @(negedge clk);
    chk("single_done", n_done - d0, 1);

    // abort in the third WAIT
    pulse_start(3, 5, 3);
    seen = 0;
    for (int c = 0; c < 200 && seen < 3; c++) begin
      if (mif.mont_start) seen++;
      if (seen < 3) @(negedge clk);
    end
    chk("third_op_seen", seen, 3);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check_outputs_zero();
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    run(3, 5, 3, 9, 7, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
